// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the pmem port arbiter: FSM states, owner codes and the default
// LSU streak limit.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int unsigned DEFAULT_MAX_STREAK = 4;
    // Wide enough for the largest legal limit (15).
    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: LSU has fixed priority unless IF has waited through
// MAX_STREAK consecutive LSU grants.
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = DEFAULT_MAX_STREAK
) (
    input  logic                if_valid,
    input  logic                lsu_valid,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_lsu
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    always_comb begin
        grant_lsu = lsu_valid & (~if_valid | (streak < STREAK_MAX));
        grant_if  = if_valid & ~grant_lsu;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single pmem port between instruction fetch and the LSU, one transaction at a
// time. Optional grant/stall counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_STREAK = DEFAULT_MAX_STREAK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         if_grant_cnt,
    output logic [31:0]         lsu_grant_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    logic grant_if, grant_lsu;
    logic in_idle, in_req, in_resp;

    mem_port_arbiter_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_arb_pick (
        .if_valid  (if_valid),
        .lsu_valid (lsu_valid),
        .streak    (streak_q),
        .grant_if  (grant_if),
        .grant_lsu (grant_lsu)
    );

    assign in_idle = (state_q == ARB_IDLE);
    assign in_req  = (state_q == ARB_REQ);
    assign in_resp = (state_q == ARB_RESP);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_lsu) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = ARB_REQ;
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = ARB_REQ;
                end
                // Streak only measures LSU grants taken while IF is actually waiting.
                if (!if_valid || grant_if) begin
                    streak_d = '0;
                end else if (grant_lsu && (streak_q != STREAK_MAX)) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end
            ARB_REQ: begin
                if (mem_req_ready) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (mem_rsp_valid) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            streak_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    always_comb begin
        if_ready      = in_idle & grant_if;
        lsu_ready     = in_idle & grant_lsu;
        mem_req_valid = in_req;
        mem_wen       = in_req & wen_q;
        mem_addr      = in_req ? addr_q  : '0;
        mem_wdata     = in_req ? wdata_q : '0;
        mem_wmask     = in_req ? wmask_q : '0;
        if_rsp_valid  = in_resp & mem_rsp_valid & (owner_q == OWN_IF);
        lsu_rsp_valid = in_resp & mem_rsp_valid & (owner_q == OWN_LSU);
        if_rdata      = if_rsp_valid ? mem_rdata : '0;
        // Write acks carry no data.
        lsu_rdata     = (lsu_rsp_valid && !wen_q) ? mem_rdata : '0;
        busy          = ~in_idle;
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grant_cnt  <= '0;
            lsu_grant_cnt <= '0;
            stall_cnt     <= '0;
        end else begin
            if (if_ready)  if_grant_cnt  <= if_grant_cnt + 32'd1;
            if (lsu_ready) lsu_grant_cnt <= lsu_grant_cnt + 32'd1;
            if ((if_valid | lsu_valid) & ~(if_ready | lsu_ready)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

    // A response outside RESP is a memory-side protocol error; it is dropped.
    stray_rsp_check: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> in_resp)
        else $warning("mem_port_arbiter: stray mem_rsp_valid outside RESP ignored");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, IF read, LSU write,
// contention ordering, request hold and stray responses.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    logic                clk;
    logic                rst_n;
    logic                if_valid;
    logic                if_ready;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_rsp_valid;
    logic [DATA_W-1:0]   if_rdata;
    logic                lsu_valid;
    logic                lsu_ready;
    logic                lsu_wen;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_rsp_valid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]         if_grant_cnt;
    logic [31:0]         lsu_grant_cnt;
    logic [31:0]         stall_cnt;
`endif

    int unsigned pass_cnt;
    int unsigned total_cnt;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_STREAK (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_wen       (lsu_wen),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_grant_cnt  (if_grant_cnt),
        .lsu_grant_cnt (lsu_grant_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic clear_inputs();
        if_valid      = 1'b0;
        if_addr       = '0;
        lsu_valid     = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        total_cnt++;
        if ({if_ready, lsu_ready, mem_req_valid, busy, if_rsp_valid, lsu_rsp_valid, mem_wen}
            !== 7'b0)
            $display("FAIL rst_ctrl_outputs: got %b want 0000000",
                     {if_ready, lsu_ready, mem_req_valid, busy, if_rsp_valid, lsu_rsp_valid,
                      mem_wen});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_valid = 1'b1;
        if_addr  = 64'h1234;
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        total_cnt++;
        if (mem_req_valid !== 1'b1) $display("FAIL rst_pre_req: got %b want 1", mem_req_valid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({mem_req_valid, busy} !== 2'b00)
            $display("FAIL rst_async: got %b want 00", {mem_req_valid, busy});
        else pass_cnt++;
        @(negedge clk);
        rst_n    = 1'b1;
        if_valid = 1'b1;
        if_addr  = 64'h8000_0000;
        #1;
        total_cnt++;
        if (if_ready !== 1'b1) $display("FAIL rst_first_accept: got %b want 1", if_ready);
        else pass_cnt++;
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        total_cnt++;
        if (mem_addr !== 64'h8000_0000)
            $display("FAIL rst_req_addr: got %h want 80000000", mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_if_read();
        do_reset();
        @(negedge clk);
        if_valid = 1'b1;
        if_addr  = 64'h8000_0004;
        #1;
        total_cnt++;
        if ({if_ready, lsu_ready} !== 2'b10)
            $display("FAIL ifrd_accept: got %b want 10", {if_ready, lsu_ready});
        else pass_cnt++;
        @(negedge clk);
        if_valid      = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        total_cnt++;
        if ({mem_req_valid, mem_wen, mem_wmask, if_ready, busy} !== {2'b10, 8'h00, 2'b01})
            $display("FAIL ifrd_req: got %b want 10_00000000_01",
                     {mem_req_valid, mem_wen, mem_wmask, if_ready, busy});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 64'h8000_0004) $display("FAIL ifrd_addr: got %h want 80000004", mem_addr);
        else pass_cnt++;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h413;
        #1;
        total_cnt++;
        if ({if_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b100)
            $display("FAIL ifrd_rsp: got %b want 100", {if_rsp_valid, lsu_rsp_valid, mem_req_valid});
        else pass_cnt++;
        total_cnt++;
        if ({if_rdata, lsu_rdata} !== {64'h413, 64'h0})
            $display("FAIL ifrd_rdata: got %h/%h want 413/0", if_rdata, lsu_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, if_rsp_valid} !== 2'b00)
            $display("FAIL ifrd_done: got %b want 00", {busy, if_rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_lsu_write();
        do_reset();
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_wen   = 1'b1;
        lsu_addr  = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        #1;
        total_cnt++;
        if ({lsu_ready, if_ready} !== 2'b10)
            $display("FAIL lsuwr_accept: got %b want 10", {lsu_ready, if_ready});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lsu_valid = 1'b0;
            lsu_wen   = 1'b0;
            lsu_addr  = 64'h5555 + 64'(i);
            lsu_wdata = 64'h0;
            lsu_wmask = 8'hF0;
            #1;
            total_cnt++;
            if ({mem_req_valid, mem_wen, mem_wmask, lsu_ready} !== {2'b11, 8'h0F, 1'b0})
                $display("FAIL lsuwr_hold_ctrl[%0d]: got %b want 11_00001111_0", i,
                         {mem_req_valid, mem_wen, mem_wmask, lsu_ready});
            else pass_cnt++;
            total_cnt++;
            if ({mem_addr, mem_wdata} !== {64'h8000_1000, 64'hDEAD_BEEF})
                $display("FAIL lsuwr_hold_data[%0d]: got %h/%h want 80001000/deadbeef", i,
                         mem_addr, mem_wdata);
            else pass_cnt++;
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        total_cnt++;
        if (mem_req_valid !== 1'b1) $display("FAIL lsuwr_hs: got %b want 1", mem_req_valid);
        else pass_cnt++;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h1234_5678;
        #1;
        total_cnt++;
        if ({lsu_rsp_valid, if_rsp_valid, lsu_rdata, if_rdata} !== {2'b10, 128'h0})
            $display("FAIL lsuwr_ack: got %b/%b rdata %h/%h want 1/0 rdata 0/0",
                     lsu_rsp_valid, if_rsp_valid, lsu_rdata, if_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, lsu_rsp_valid} !== 2'b00)
            $display("FAIL lsuwr_done: got %b want 00", {busy, lsu_rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_contention();
        // Bit i is 1 when grant i must go to the LSU: L,L,L,L,I,L,L,L,L,I.
        logic [9:0] exp_lsu;
        exp_lsu = 10'b01_1110_1111;
        do_reset();
        @(negedge clk);
        if_valid      = 1'b1;
        if_addr       = 64'h8000_0100;
        lsu_valid     = 1'b1;
        lsu_addr      = 64'h8000_2000;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rsp_valid = 1'b0;
            #1;
            total_cnt++;
            if ({lsu_ready, if_ready} !== {exp_lsu[i], ~exp_lsu[i]})
                $display("FAIL cont_grant[%0d]: got lsu/if %b%b want %b%b", i, lsu_ready,
                         if_ready, exp_lsu[i], ~exp_lsu[i]);
            else pass_cnt++;
            @(negedge clk);
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rdata     = 64'(i);
            #1;
            total_cnt++;
            if ({lsu_rsp_valid, if_rsp_valid} !== {exp_lsu[i], ~exp_lsu[i]})
                $display("FAIL cont_rsp[%0d]: got lsu/if %b%b want %b%b", i, lsu_rsp_valid,
                         if_rsp_valid, exp_lsu[i], ~exp_lsu[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_request_hold();
        do_reset();
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_wen   = 1'b0;
        lsu_addr  = 64'h8000_0100;
        #1;
        total_cnt++;
        if (lsu_ready !== 1'b1) $display("FAIL hold_accept: got %b want 1", lsu_ready);
        else pass_cnt++;
        @(negedge clk);
        lsu_addr      = 64'h8000_0200;
        mem_req_ready = 1'b1;
        #1;
        total_cnt++;
        if ({mem_addr, mem_wen} !== {64'h8000_0100, 1'b0})
            $display("FAIL hold_addr: got %h wen %b want 80000100 wen 0", mem_addr, mem_wen);
        else pass_cnt++;
        @(negedge clk);
        lsu_valid     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hCAFE_F00D;
        #1;
        total_cnt++;
        if ({lsu_rsp_valid, lsu_rdata, if_rdata} !== {1'b1, 64'hCAFE_F00D, 64'h0})
            $display("FAIL hold_load: got %b %h/%h want 1 cafef00d/0", lsu_rsp_valid,
                     lsu_rdata, if_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_stray_response();
        do_reset();
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hFFFF;
        #1;
        total_cnt++;
        if ({if_rsp_valid, lsu_rsp_valid, busy, if_rdata, lsu_rdata} !== {3'b000, 128'h0})
            $display("FAIL stray_idle: got %b%b%b %h/%h want 000 0/0", if_rsp_valid,
                     lsu_rsp_valid, busy, if_rdata, lsu_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        if_valid      = 1'b1;
        if_addr       = 64'h40;
        @(negedge clk);
        if_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        total_cnt++;
        if ({if_rsp_valid, mem_req_valid} !== 2'b01)
            $display("FAIL stray_req: got %b want 01", {if_rsp_valid, mem_req_valid});
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({mem_req_valid, busy} !== 2'b11)
            $display("FAIL stray_req_hold: got %b want 11", {mem_req_valid, busy});
        else pass_cnt++;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_if_read();
        test_lsu_write();
        test_contention();
        test_request_hold();
        test_stray_response();
        do_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
